nco_tdm_ctrl: RTL

NCO_TDM_CTRL -- requirements
Module: nco_tdm_ctrl

---
 rtl/nco_tdm_ctrl_if.sv | 27 ++
 rtl/nco_tdm_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/nco_tdm_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : nco_tdm_ctrl_if
// Description : Configuration write bus for nco_tdm_ctrl (valid/ready handshake
//               carrying target channel, register select and 32-bit data).
// Revision    : 1.0 - initial release
// ============================================================================
interface nco_tdm_ctrl_if #(
  parameter int NCH = 4
);
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [$clog2(NCH)-1:0] cfg_ch;
  logic [1:0]             cfg_sel;
  logic [31:0]            cfg_data;

  modport master (
    output cfg_valid, cfg_ch, cfg_sel, cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_sel, cfg_data,
    output cfg_ready
  );
endinterface
`default_nettype wire

// File: rtl/nco_tdm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nco_tdm_ctrl
// Description : Time-division-multiplexed NCO controller. Holds per-channel
//               frequency word, phase offset and accumulator, issues one
//               channel phase per enabled cycle to a shared sincos pipeline
//               and tags the returning samples with valid/channel.
//               Optional build macro NCO_DITHER_EN adds LFSR phase dither.
// Revision    : 1.0 - initial release
// ============================================================================
module nco_tdm_ctrl #(
  parameter int NCH = 4,
  parameter int NBA = 22,
  parameter int NBD = 18,
  parameter int LAT = 6
) (
  input  logic                   c,
  input  logic                   r,
  input  logic                   en,
  nco_tdm_ctrl_if.slave          cfg,
  output logic [NBA-1:0]         ph,
  input  logic signed [NBD-1:0]  sc_cos,
  input  logic signed [NBD-1:0]  sc_sin,
  output logic                   o_valid,
  output logic [$clog2(NCH)-1:0] o_ch,
  output logic signed [NBD-1:0]  o_cos,
  output logic signed [NBD-1:0]  o_sin
);
  localparam int CW = $clog2(NCH);
  localparam int DW = 32 - NBA;   // phase bits dropped by truncation

  logic [CW-1:0] s;
  logic [31:0]   f_word [NCH];
  logic [31:0]   p_off  [NCH];
  logic [31:0]   acc    [NCH];
  logic [31:0]   sum;
  logic          cfg_fire;
  logic          tag_v  [LAT+1];
  logic [CW-1:0] tag_ch [LAT+1];

  // A write aimed at the slot being issued this cycle is held off so the
  // accumulator update and the config write never collide.
  assign cfg.cfg_ready = ~r & ~(en & (cfg.cfg_ch == s));
  assign cfg_fire      = cfg.cfg_valid & cfg.cfg_ready;

`ifdef NCO_DITHER_EN
  localparam logic [31:0] DMASK = (32'd1 << DW) - 32'd1;

  logic [15:0] lfsr;
  logic [31:0] dith;

  assign dith = {16'd0, lfsr} & DMASK;
  assign sum  = acc[s] + p_off[s] + dith;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, one step per issued slot.
  always_ff @(posedge c) begin
    if (r) begin
      lfsr <= 16'hACE1;
    end else if (en) begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end
`else
  assign sum = acc[s] + p_off[s];
`endif

  // Slot issue, accumulator update and configuration writes.
  always_ff @(posedge c) begin
    if (r) begin
      s  <= '0;
      ph <= '0;
      for (int i = 0; i < NCH; i++) begin
        f_word[i] <= '0;
        p_off[i]  <= '0;
        acc[i]    <= '0;
      end
    end else begin
      if (en) begin
        acc[s] <= acc[s] + f_word[s];
        ph     <= NBA'(sum >> DW);
        s      <= s + 1'b1;
      end
      if (cfg_fire) begin
        case (cfg.cfg_sel)
          2'd0:    f_word[cfg.cfg_ch] <= cfg.cfg_data;
          2'd1:    p_off[cfg.cfg_ch]  <= cfg.cfg_data;
          2'd2:    acc[cfg.cfg_ch]    <= '0;
          default: ;
        endcase
      end
    end
  end

  // Tag pipe: tag[0] is captured with ph, the output register follows
  // tag[LAT], landing alongside o_cos/o_sin for that phase.
  always_ff @(posedge c) begin
    if (r) begin
      for (int i = 0; i <= LAT; i++) begin
        tag_v[i]  <= 1'b0;
        tag_ch[i] <= '0;
      end
      o_valid <= 1'b0;
      o_ch    <= '0;
    end else begin
      tag_v[0]  <= en;
      tag_ch[0] <= s;
      for (int i = 1; i <= LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_ch[i] <= tag_ch[i-1];
      end
      o_valid <= tag_v[LAT];
      o_ch    <= tag_ch[LAT];
    end
  end

  // Sample capture from the sincos pipeline, unconditional every cycle.
  always_ff @(posedge c) begin
    if (r) begin
      o_cos <= '0;
      o_sin <= '0;
    end else begin
      o_cos <= sc_cos;
      o_sin <= sc_sin;
    end
  end
endmodule
`default_nettype wire
